// File: rtl/uart_rx_pkg.sv
// Shared state type, counter sizing helper and default bit period for the UART receiver.
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // PARITY keeps a fixed encoding so both builds share one state map.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the mid-bit and end-of-bit counts.
module uart_baud_counter
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_half_tick,
    output logic o_full_tick
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = (cnt_q == FULL_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_half_tick = (cnt_q == HALF_LAST);
    assign o_full_tick = (cnt_q == FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: mid-bit sampling FSM, LSB-first assembly, valid/ready output.
// Optional parity check is built when UART_RX_PARITY_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for a start-edge strobe while enabled
//   START  | half a bit period, then confirm the start bit is still low
//   DATA   | sample one data bit per bit period, LSB first
//   PARITY | sample the parity bit (parity build only)
//   STOP   | sample the stop bit, deliver or flag the byte, return to IDLE
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    output logic                 o_rx_en,
    input  logic                 i_start_signal,
    input  logic                 i_rx_in,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_en_q, rx_en_d;
    logic                 half_tick, full_tick;
    logic                 cnt_clear;
    logic                 byte_done;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 parity_err_q, parity_err_d;
    logic                 parity_ok;
`endif

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (cnt_clear),
        .i_enable    (state_q != IDLE),
        .o_half_tick (half_tick),
        .o_full_tick (full_tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
        parity_ok    = (((^shift_q) ^ par_bit_q) == PARITY_ODD[0]);
`endif
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (i_start_signal && rx_en_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_tick) begin
                    bit_idx_d = '0;
                    state_d   = i_rx_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_idx_q == 3'(i)) begin
                            shift_d[i] = i_rx_in;
                        end
                    end
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    par_bit_d = i_rx_in;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    state_d     = IDLE;
                    frame_err_d = !i_rx_in;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = !parity_ok;
                    byte_done    = i_rx_in && parity_ok;
`else
                    byte_done    = i_rx_in;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything in flight; the held output byte is left alone.
        if ((state_q != IDLE) && !i_enable) begin
            state_d     = IDLE;
            bit_idx_d   = '0;
            byte_done   = 1'b0;
            frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
    end

    assign cnt_clear = (state_q == IDLE) || (state_d != state_q);
    assign rx_en_d   = i_enable;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_en_q     <= rx_en_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign o_parity_err = parity_err_q;
`endif

    assign o_rx_en     = rx_en_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (16 clocks/bit, 8 data bits); covers UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int CLKS  = 16;
    localparam int DBITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = DBITS + 3;
`else
    localparam int FRAME_BITS = DBITS + 2;
`endif
    localparam logic PODD = 1'b0;
    // Clocks from line fall to the stop-bit sample edge, plus one for the output register.
    localparam int STOP_SAMPLE = CLKS / 2 + CLKS * (FRAME_BITS - 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       ready = 1'b0;
    logic       rx_line = 1'b1;
    logic       line_prev = 1'b1;
    logic       start_strobe;
    logic       rx_en, valid, frame_err, overrun, busy;
    logic [7:0] data;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_mis = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int rise_cyc = 0;
    int last_fall = 0;
    logic valid_prev = 1'b0;
    logic [7:0] act_q[$];
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (DBITS)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD   (0)
`endif
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .o_rx_en        (rx_en),
        .i_start_signal (start_strobe),
        .i_rx_in        (rx_line),
        .o_data         (data),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_frame_err    (frame_err),
        .o_overrun      (overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_err   (parity_err),
`endif
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        line_prev <= rx_line;
    end

    // Behavioural front-end: strobe on a falling line.
    assign start_strobe = line_prev & ~rx_line;

    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (valid && ready) act_q.push_back(data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (valid && !valid_prev) rise_cyc = cyc;
            valid_prev = valid;
        end else begin
            valid_prev = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        logic [DBITS+2:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DBITS; i++) bits[1+i] = d[i];
        bits[DBITS+1] = par_bit;
        bits[FRAME_BITS-1] = stop_bit;
        last_fall = cyc;
        for (int b = 0; b < FRAME_BITS; b++) begin
            rx_line = bits[b];
            repeat (CLKS) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic consume();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    logic [7:0] rd;
    logic       rsb, rr, mdl_valid;
    logic [7:0] mdl_data;
    int         fe0, ov0, pe0, exp_fe, exp_ov;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_rx_en", rx_en, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rx_en_on", rx_en, 1);

        // Basic byte, held while not ready
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1, (^8'hA5) ^ PODD);
        check_eq("a5_valid", valid, 1);
        check_eq("a5_data", data, 8'hA5);
        check_eq("a5_latency", rise_cyc - last_fall, STOP_SAMPLE + 1);
        check_eq("a5_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        repeat (20) @(negedge clk);
        check_eq("a5_hold_data", data, 8'hA5);
        check_eq("a5_hold_valid", valid, 1);
        consume();
        exp_q.push_back(8'hA5);
        check_eq("a5_cleared", valid, 0);

        // Start glitch
        fe0 = fe_cnt;
        rx_line = 1'b0;
        @(negedge clk);
        check_eq("glitch_busy", busy, 1);
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("glitch_idle", busy, 0);
        check_eq("glitch_valid", valid, 0);
        check_eq("glitch_fe", fe_cnt - fe0, 0);

        // Framing error
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, (^8'h3C) ^ PODD);
        repeat (2) @(negedge clk);
        check_eq("fe_pulse", fe_cnt - fe0, 1);
        check_eq("fe_valid", valid, 0);
        check_eq("fe_data", data, 8'hA5);

        // Overrun, then load coinciding with handshake
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, (^8'h11) ^ PODD);
        check_eq("ov_first", data, 8'h11);
        send_frame(8'h22, 1'b1, (^8'h22) ^ PODD);
        check_eq("ov_pulse", ov_cnt - ov0, 1);
        check_eq("ov_held", data, 8'h11);
        check_eq("ov_valid", valid, 1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h33, 1'b1, (^8'h33) ^ PODD);
            begin
                repeat (STOP_SAMPLE) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                check_eq("swap_valid", valid, 1);
                check_eq("swap_data", data, 8'h33);
                ready = 1'b0;
            end
        join
        exp_q.push_back(8'h11);
        check_eq("swap_no_ov", ov_cnt - ov0, 0);
        consume();
        exp_q.push_back(8'h33);

        // Disable mid-frame
        fe0 = fe_cnt;
        fork
            send_frame(8'h4B, 1'b1, (^8'h4B) ^ PODD);
            begin
                repeat (CLKS / 2 + CLKS * 3 + 4) @(negedge clk);
                check_eq("dis_busy_before", busy, 1);
                enable = 1'b0;
                @(negedge clk);
                check_eq("dis_busy_after", busy, 0);
                check_eq("dis_rx_en", rx_en, 0);
            end
        join
        repeat (2) @(negedge clk);
        check_eq("dis_valid", valid, 0);
        check_eq("dis_data", data, 8'h33);
        check_eq("dis_fe", fe_cnt - fe0, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h7E, 1'b1, (^8'h7E) ^ PODD);
        check_eq("reen_valid", valid, 1);
        check_eq("reen_data", data, 8'h7E);
        consume();
        exp_q.push_back(8'h7E);

        // Randomized frames against a frame-level model of the output register
        mdl_valid = 1'b0;
        mdl_data  = 8'h7E;
        for (int f = 0; f < 16; f++) begin
            rd  = 8'($urandom);
            rsb = ($urandom_range(0, 4) != 0);
            rr  = 1'($urandom_range(0, 1));
            fe0 = fe_cnt; ov0 = ov_cnt;
            exp_fe = 0; exp_ov = 0;
            ready = rr;
            if (rr && mdl_valid) begin
                exp_q.push_back(mdl_data);
                mdl_valid = 1'b0;
            end
            repeat ($urandom_range(2, 12)) @(negedge clk);
            send_frame(rd, rsb, (^rd) ^ PODD);
            repeat (2) @(negedge clk);
            if (!rsb) begin
                exp_fe = 1;
            end else if (!mdl_valid) begin
                mdl_data = rd;
                if (rr) exp_q.push_back(rd);
                else mdl_valid = 1'b1;
            end else begin
                exp_ov = 1;
            end
            check_eq("rnd_fe", fe_cnt - fe0, exp_fe);
            check_eq("rnd_ov", ov_cnt - ov0, exp_ov);
            check_eq("rnd_valid", valid, mdl_valid);
            check_eq("rnd_data", data, mdl_data);
        end
        ready = 1'b1;
        if (mdl_valid) exp_q.push_back(mdl_data);
        repeat (2) @(negedge clk);
        ready = 1'b0;

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        check_eq("par_ok_valid", valid, 1);
        check_eq("par_ok_data", data, 8'h07);
        check_eq("par_ok_pe", pe_cnt - pe0, 0);
        consume();
        exp_q.push_back(8'h07);
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("par_bad_pe", pe_cnt - pe0, 1);
        check_eq("par_bad_valid", valid, 0);
        check_eq("par_bad_fe", fe_cnt - fe0, 0);
`else
        pe0 = pe_cnt;
`endif

        // Reset in the middle of a frame, with a byte held
        send_frame(8'h5D, 1'b1, (^8'h5D) ^ PODD);
        check_eq("prerst_valid", valid, 1);
        fork
            send_frame(8'hC3, 1'b1, (^8'hC3) ^ PODD);
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_eq("mrst_rx_en", rx_en, 0);
                check_eq("mrst_valid", valid, 0);
                check_eq("mrst_data", data, 0);
                check_eq("mrst_fe", frame_err, 0);
                check_eq("mrst_ov", overrun, 0);
                check_eq("mrst_busy", busy, 0);
            end
        join
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("postrst_rx_en", rx_en, 1);
        check_eq("postrst_busy", busy, 0);

        check_eq("acc_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check_eq("acc_byte", act_q[i], exp_q[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
